// File: rtl/obstacle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_controller
//  Description : Single-obstacle game controller. Spawns an obstacle at the
//                far edge of the play field, walks it toward the player once
//                per frame strobe, and respawns it in a pseudo-random lane
//                when it is cleared. Clears add to the score, and every few
//                clears the obstacle speeds up. A collision freezes the game
//                until the next start request.
//  Revision    : 1.0 - initial release
// ============================================================================
module obstacle_controller #(
   parameter int X_BITWIDTH    = 8,
   parameter int Y_BITWIDTH    = 9,
   parameter int Y_START       = 320,
   parameter int X_GROUND      = 40,
   parameter int X_AIR         = 100,
   parameter int STEP_INIT     = 2,
   parameter int STEP_MAX      = 8,
   parameter int SPEEDUP_COUNT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  update,
   input  logic                  start,
   input  logic                  collision,
   output logic [X_BITWIDTH-1:0] xObstacle,
   output logic [Y_BITWIDTH-1:0] yObstacle,
   output logic [3:0]            IdObstacle,
   output logic [15:0]           score,
   output logic                  active,
   output logic                  gameOver
);

   // Width of the cleared-obstacle counter; at least one bit even when every
   // clear is a speed-up.
   localparam int PASS_W = (SPEEDUP_COUNT > 1) ? $clog2(SPEEDUP_COUNT) : 1;

   localparam logic [X_BITWIDTH-1:0] cXGround  = X_BITWIDTH'(X_GROUND);
   localparam logic [X_BITWIDTH-1:0] cXAir     = X_BITWIDTH'(X_AIR);
   localparam logic [Y_BITWIDTH-1:0] cYStart   = Y_BITWIDTH'(Y_START);
   localparam logic [3:0]            cStepInit = 4'(STEP_INIT);
   localparam logic [3:0]            cStepMax  = 4'(STEP_MAX);
   localparam logic [PASS_W-1:0]     cPassLast = PASS_W'(SPEEDUP_COUNT - 1);
   localparam logic [7:0]            cLfsrSeed = 8'hA5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HIT  = 2'd2
   } state_t;

   state_t              rState;
   logic [3:0]          rStep;
   logic [PASS_W-1:0]   rPassed;
   logic [7:0]          rLfsr;

   logic [Y_BITWIDTH-1:0] wStepExt;
   logic                  wRespawn;
   logic                  wLfsrFb;
   logic [15:0]           wScoreNext;
   logic [3:0]            wStepNext;
   logic                  wPassWrap;

   // Step is compared and subtracted at full y width so a small y never wraps.
   assign wStepExt   = Y_BITWIDTH'(rStep);
   assign wRespawn   = (yObstacle <= wStepExt);
   // Taps 8,6,5,4 (bits 7,5,4,3) give a maximal-length sequence, so a non-zero
   // seed never reaches the all-zero lock-up state.
   assign wLfsrFb    = rLfsr[7] ^ rLfsr[5] ^ rLfsr[4] ^ rLfsr[3];
   assign wScoreNext = (score == 16'hFFFF) ? score : score + 16'd1;
   assign wStepNext  = (rStep >= cStepMax) ? rStep : rStep + 4'd1;
   assign wPassWrap  = (rPassed == cPassLast);

   // Lane-selection LFSR: free-running in every state so the lane sequence
   // depends on how long the player waited between games.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rLfsr <= cLfsrSeed;
      end else begin
         rLfsr <= {rLfsr[6:0], wLfsrFb};
      end
   end

   // Game state machine with registered status and obstacle outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rState     <= IDLE;
         xObstacle  <= cXGround;
         yObstacle  <= cYStart;
         IdObstacle <= 4'd0;
         score      <= 16'd0;
         rStep      <= cStepInit;
         rPassed    <= '0;
         active     <= 1'b0;
         gameOver   <= 1'b0;
      end else begin
         case (rState)
            IDLE, HIT: begin
               // Everything stays frozen until a (re)start request.
               if (start) begin
                  rState     <= RUN;
                  xObstacle  <= cXGround;
                  yObstacle  <= cYStart;
                  IdObstacle <= 4'd0;
                  score      <= 16'd0;
                  rStep      <= cStepInit;
                  rPassed    <= '0;
                  active     <= 1'b1;
                  gameOver   <= 1'b0;
               end
            end
            RUN: begin
               // Collision has priority over a same-cycle frame update, so the
               // frozen position is the one the checker actually saw.
               if (collision) begin
                  rState   <= HIT;
                  active   <= 1'b0;
                  gameOver <= 1'b1;
               end else if (update) begin
                  if (wRespawn) begin
                     yObstacle <= cYStart;
                     if (rLfsr[0]) begin
                        xObstacle  <= cXAir;
                        IdObstacle <= 4'd1;
                     end else begin
                        xObstacle  <= cXGround;
                        IdObstacle <= 4'd0;
                     end
                     score <= wScoreNext;
                     if (wPassWrap) begin
                        rPassed <= '0;
                        rStep   <= wStepNext;
                     end else begin
                        rPassed <= rPassed + PASS_W'(1);
                     end
                  end else begin
                     yObstacle <= yObstacle - wStepExt;
                  end
               end
            end
            default: begin
               rState   <= IDLE;
               active   <= 1'b0;
               gameOver <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obstacle_controller
//  Description : Self-checking bench for obstacle_controller. A reference
//                model predicts every output after each clock; predictions are
//                queued when stimulus is driven and compared after the edge.
//                A vector table covers the basic game flow, hand-written
//                sequences cover the multi-cycle corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        update = 1'b0;
   logic        start = 1'b0;
   logic        collision = 1'b0;
   logic [7:0]  xObstacle;
   logic [8:0]  yObstacle;
   logic [3:0]  IdObstacle;
   logic [15:0] score;
   logic        active;
   logic        gameOver;

   obstacle_controller dut (
      .clock      (clock),
      .reset      (reset),
      .update     (update),
      .start      (start),
      .collision  (collision),
      .xObstacle  (xObstacle),
      .yObstacle  (yObstacle),
      .IdObstacle (IdObstacle),
      .score      (score),
      .active     (active),
      .gameOver   (gameOver)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [3:0]  id;
      logic [15:0] score;
      logic        active;
      logic        over;
   } exp_t;

   exp_t sbq[$];

   // Reference model state (0 idle, 1 run, 2 hit)
   int          mState;
   logic [7:0]  mX;
   logic [8:0]  mY;
   logic [3:0]  mId;
   logic [15:0] mScore;
   int          mStep;
   int          mPassed;
   logic [7:0]  mLfsr;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic modelReset();
      mState = 0; mX = 8'd40; mY = 9'd320; mId = 4'd0; mScore = 16'd0;
      mStep = 2; mPassed = 0; mLfsr = 8'hA5;
   endtask

   task automatic modelSpawn();
      mState = 1; mX = 8'd40; mY = 9'd320; mId = 4'd0; mScore = 16'd0;
      mStep = 2; mPassed = 0;
   endtask

   // One clock of the reference model, from the values before the edge.
   task automatic modelAdvance(input logic st, input logic up, input logic co);
      logic lane;
      lane = mLfsr[0];
      case (mState)
         0, 2: if (st) modelSpawn();
         default: begin
            if (co) mState = 2;
            else if (up) begin
               if (int'(mY) <= mStep) begin
                  mY = 9'd320;
                  if (lane) begin mX = 8'd100; mId = 4'd1; end
                  else      begin mX = 8'd40;  mId = 4'd0; end
                  if (mScore != 16'hFFFF) mScore = mScore + 16'd1;
                  if (mPassed == 3) begin
                     mPassed = 0;
                     if (mStep < 8) mStep = mStep + 1;
                  end else mPassed = mPassed + 1;
               end else mY = mY - 9'(mStep);
            end
         end
      endcase
      mLfsr = {mLfsr[6:0], mLfsr[7] ^ mLfsr[5] ^ mLfsr[4] ^ mLfsr[3]};
   endtask

   // Drive one cycle of stimulus (caller sits just after an active edge),
   // queue the prediction, then compare just after the next edge.
   task automatic cycle(input logic st, input logic up, input logic co);
      exp_t e;
      start = st; update = up; collision = co;
      modelAdvance(st, up, co);
      e.x = mX; e.y = mY; e.id = mId; e.score = mScore;
      e.active = (mState == 1); e.over = (mState == 2);
      sbq.push_back(e);
      @(posedge clock); #1;
      if (sbq.size() == 0) begin
         total++; bad++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = sbq.pop_front();
         check("sb_x",      xObstacle,  e.x);
         check("sb_y",      yObstacle,  e.y);
         check("sb_id",     IdObstacle, e.id);
         check("sb_score",  score,      e.score);
         check("sb_active", active,     e.active);
         check("sb_over",   gameOver,   e.over);
      end
   endtask

   task automatic runUntilScore(input int target);
      int guard;
      guard = 0;
      while (int'(mScore) < target && guard < 5000) begin
         cycle(1'b0, 1'b1, 1'b0);
         guard++;
      end
      if (guard >= 5000) begin
         total++; bad++;
         $display("FAIL runUntilScore: got score %0d, expected %0d within budget", score, target);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      check({tag, "_x"},      xObstacle,  40);
      check({tag, "_y"},      yObstacle,  320);
      check({tag, "_id"},     IdObstacle, 0);
      check({tag, "_score"},  score,      0);
      check({tag, "_active"}, active,     0);
      check({tag, "_over"},   gameOver,   0);
   endtask

   typedef struct {
      logic st;
      logic up;
      logic co;
      int   expY;
      int   expScore;
      logic expActive;
      logic expOver;
   } vec_t;

   vec_t vecs[16];

   initial begin
      // Game flow: start, 10 updates, idle frame, start ignored in RUN,
      // collision beating update, frozen HIT, restart.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 320, 0, 1'b1, 1'b0};
      for (int i = 1; i <= 10; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 320 - 2 * i, 0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 300, 0, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 298, 0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 298, 0, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 298, 0, 1'b0, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 320, 0, 1'b1, 1'b0};

      modelReset();
      repeat (3) @(posedge clock);
      #1;
      checkResetOutputs("reset");
      reset = 1'b1;

      // Idle: updates ignored before start
      cycle(1'b0, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         cycle(vecs[i].st, vecs[i].up, vecs[i].co);
         check($sformatf("vec%0d_y", i),      yObstacle, vecs[i].expY);
         check($sformatf("vec%0d_score", i),  score,     vecs[i].expScore);
         check($sformatf("vec%0d_active", i), active,    vecs[i].expActive);
         check($sformatf("vec%0d_over", i),   gameOver,  vecs[i].expOver);
      end

      // Collision together with update at y=150
      repeat (85) cycle(1'b0, 1'b1, 1'b0);
      check("pre_hit_y", yObstacle, 150);
      cycle(1'b0, 1'b1, 1'b1);
      check("hit_over", gameOver, 1);
      check("hit_y",    yObstacle, 150);
      repeat (3) cycle(1'b0, 1'b1, 1'b0);
      check("hit_frozen_y", yObstacle, 150);
      cycle(1'b1, 1'b0, 1'b0);
      check("restart_y",      yObstacle, 320);
      check("restart_score",  score, 0);
      check("restart_active", active, 1);

      // First clear: y=2 with step 2 respawns
      runUntilScore(1);
      check("clear1_y",     yObstacle, 320);
      check("clear1_score", score, 1);
      check("clear1_lane",  xObstacle, (IdObstacle == 4'd1) ? 100 : 40);

      // Speed-up after 4 clears, saturation at 8
      runUntilScore(4);
      cycle(1'b0, 1'b1, 1'b0);
      check("step3_y", yObstacle, 317);
      runUntilScore(32);
      cycle(1'b0, 1'b1, 1'b0);
      check("step8_y", yObstacle, 312);
      runUntilScore(36);
      cycle(1'b0, 1'b1, 1'b0);
      check("step8_sat_y", yObstacle, 312);

      // start held high during RUN must not restart
      repeat (50) cycle(1'b1, 1'b1, 1'b0);
      check("hold_start_active", active, 1);
      check("hold_start_score",  score >= 16'd36, 1);

      // Asynchronous reset pulse between edges
      #1 reset = 1'b0;
      #1 checkResetOutputs("async");
      #1 reset = 1'b1;
      start = 1'b0; update = 1'b0; collision = 1'b0;
      modelReset();
      sbq.delete();
      cycle(1'b0, 1'b0, 1'b0);
      check("post_reset_idle", active, 0);
      cycle(1'b1, 1'b0, 1'b0);
      runUntilScore(3);
      check("post_reset_score", score, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
